// File: rtl/bram_gather_if.sv
// rtl/bram_gather_if.sv - start/result handshake and BRAM read port bundle for bram_gather; abort_i exists only with BRAM_GATHER_ABORT_EN
interface bram_gather_if #(
    parameter int ADDRESS_WIDTH   = 13,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int DATA_OUT_WIDTH  = 512
);
    logic                       start_i;
    logic                       busy_o;
    logic                       valid_o;
    logic [DATA_OUT_WIDTH-1:0]  data_o;
    logic [ADDRESS_WIDTH-1:0]   bram_addr;
    logic                       bram_en;
    logic [3:0]                 bram_we;
    logic [BRAM_DATA_WIDTH-1:0] bram_data_out;

`ifdef BRAM_GATHER_ABORT_EN
    logic                       abort_i;

    modport slave (
        input  start_i, abort_i, bram_data_out,
        output busy_o, valid_o, data_o, bram_addr, bram_en, bram_we
    );
    modport master (
        output start_i, abort_i, bram_data_out,
        input  busy_o, valid_o, data_o, bram_addr, bram_en, bram_we
    );
`else
    modport slave (
        input  start_i, bram_data_out,
        output busy_o, valid_o, data_o, bram_addr, bram_en, bram_we
    );
    modport master (
        output start_i, bram_data_out,
        input  busy_o, valid_o, data_o, bram_addr, bram_en, bram_we
    );
`endif
endinterface

// File: rtl/bram_gather.sv
// rtl/bram_gather.sv - gathers N consecutive BRAM words into one wide result; optional abort with BRAM_GATHER_ABORT_EN
module bram_gather #(
    parameter int          ADDRESS_WIDTH   = 13,
    parameter int          BRAM_DATA_WIDTH = 32,
    parameter int          DATA_OUT_WIDTH  = 512,
    parameter int unsigned BASE_ADDRESS    = 5,
    parameter int          READ_LATENCY    = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    bram_gather_if.slave bus
);
    localparam int N  = DATA_OUT_WIDTH / BRAM_DATA_WIDTH;
    localparam int CW = $clog2(N) + 1;
    localparam logic [ADDRESS_WIDTH-1:0] BASE   = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [CW-1:0]            LAST   = CW'(N - 1);
    localparam logic [CW-1:0]            NWORDS = CW'(N);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                     state, state_next;
    logic                       busy_q, busy_next;
    logic                       valid_q, valid_next;
    logic                       en_q, en_next;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_next;
    logic [DATA_OUT_WIDTH-1:0]  data_q, data_next;
    logic [DATA_OUT_WIDTH-1:0]  asm_q, asm_shift;
    logic [CW-1:0]              issue_cnt, issue_next;
    logic [CW-1:0]              cap_cnt, cap_inc;
    logic [READ_LATENCY:0]      tag_q;
    logic                       capture;
    logic                       start_accept;
    logic                       abort;

`ifdef BRAM_GATHER_ABORT_EN
    assign abort = bus.abort_i;
`else
    assign abort = 1'b0;
`endif

    assign capture   = tag_q[READ_LATENCY];
    assign cap_inc   = cap_cnt + CW'(1);
    // New word enters at the MSB end so the lowest address ends up in the LSBs.
    assign asm_shift = (asm_q >> BRAM_DATA_WIDTH)
                     | (DATA_OUT_WIDTH'(bus.bram_data_out) << (DATA_OUT_WIDTH - BRAM_DATA_WIDTH));

    always_comb begin
        state_next   = state;
        busy_next    = busy_q;
        valid_next   = 1'b0;
        en_next      = 1'b0;
        addr_next    = addr_q;
        data_next    = data_q;
        issue_next   = issue_cnt;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    start_accept = 1'b1;
                    state_next   = ISSUE;
                    busy_next    = 1'b1;
                    en_next      = 1'b1;
                    addr_next    = BASE;
                    issue_next   = '0;
                end
            end
            ISSUE: begin
                issue_next = issue_cnt + CW'(1);
                if (issue_cnt == LAST) begin
                    state_next = DRAIN;
                end else begin
                    en_next   = 1'b1;
                    addr_next = addr_q + ADDRESS_WIDTH'(1);
                end
            end
            DRAIN: begin
                // Finish on the edge that captures the last word, not one edge later.
                if (capture && cap_inc == NWORDS) begin
                    data_next  = asm_shift;
                    valid_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next   = IDLE;
            busy_next    = 1'b0;
            valid_next   = 1'b0;
            en_next      = 1'b0;
            addr_next    = BASE;
            data_next    = data_q;
            start_accept = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= BASE;
            data_q    <= '0;
            asm_q     <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            tag_q     <= '0;
        end else begin
            state     <= state_next;
            busy_q    <= busy_next;
            valid_q   <= valid_next;
            en_q      <= en_next;
            addr_q    <= addr_next;
            data_q    <= data_next;
            issue_cnt <= issue_next;
            if (abort) begin
                tag_q   <= '0;
                cap_cnt <= '0;
            end else begin
                tag_q <= {tag_q[READ_LATENCY-1:0], en_next};
                if (start_accept) begin
                    cap_cnt <= '0;
                end else if (capture) begin
                    cap_cnt <= cap_inc;
                end
                if (capture) begin
                    asm_q <= asm_shift;
                end
            end
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.valid_o   = valid_q;
    assign bus.data_o    = data_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_en   = en_q;
    assign bus.bram_we   = 4'b0000;
endmodule

// File: tb/tb_bram_gather.sv
// tb/tb_bram_gather.sv - directed bench for bram_gather: default, READ_LATENCY=2 and wrapping-address instances; abort sequence with BRAM_GATHER_ABORT_EN
module tb_bram_gather;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_gather_if #(.ADDRESS_WIDTH(13), .BRAM_DATA_WIDTH(32), .DATA_OUT_WIDTH(512)) if_a ();
    bram_gather_if #(.ADDRESS_WIDTH(13), .BRAM_DATA_WIDTH(32), .DATA_OUT_WIDTH(512)) if_b ();
    bram_gather_if #(.ADDRESS_WIDTH(4),  .BRAM_DATA_WIDTH(32), .DATA_OUT_WIDTH(128)) if_c ();

    bram_gather #(.ADDRESS_WIDTH(13), .BRAM_DATA_WIDTH(32), .DATA_OUT_WIDTH(512),
                  .BASE_ADDRESS(5), .READ_LATENCY(1))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
    bram_gather #(.ADDRESS_WIDTH(13), .BRAM_DATA_WIDTH(32), .DATA_OUT_WIDTH(512),
                  .BASE_ADDRESS(5), .READ_LATENCY(2))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));
    bram_gather #(.ADDRESS_WIDTH(4), .BRAM_DATA_WIDTH(32), .DATA_OUT_WIDTH(128),
                  .BASE_ADDRESS(14), .READ_LATENCY(1))
        dut_c (.clk_i(clk), .rst_i(rst), .bus(if_c.slave));

    // Memory contents: A/B word at 5+k is A000_0000+k; C word at address a is C000_0000+a.
    logic [31:0] rd_a, rd_b1, rd_b2, rd_c;
    always_ff @(posedge clk) begin
        if (if_a.bram_en) rd_a  <= 32'hA000_0000 + 32'(if_a.bram_addr) - 32'd5;
        if (if_b.bram_en) rd_b1 <= 32'hA000_0000 + 32'(if_b.bram_addr) - 32'd5;
        rd_b2 <= rd_b1;
        if (if_c.bram_en) rd_c  <= 32'hC000_0000 + 32'(if_c.bram_addr);
    end
    assign if_a.bram_data_out = rd_a;
    assign if_b.bram_data_out = rd_b2;
    assign if_c.bram_data_out = rd_c;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int en_cnt;
        int addr_bad;
        int valid_cnt;
        int valid_first;
        int valid_last;
    } obs_t;

    obs_t oa, ob, oc;
    logic busy_hist [64];

    task automatic sample(input int c, input logic en, input int addr, input int base,
                          input int amod, input int n, input logic valid, inout obs_t o);
        if (en) o.en_cnt++;
        if (c < n && (en !== 1'b1 || addr != (base + c) % amod)) o.addr_bad++;
        if (valid) begin
            o.valid_cnt++;
            if (o.valid_first < 0) o.valid_first = c;
            o.valid_last = c;
        end
    endtask

    // mode 0: single start pulse, 1: start held, 2: single pulse plus re-pulses while busy
    task automatic observe(input int ncyc, input int mode, input bit use_a, input bit use_b, input bit use_c);
        oa = '{0, 0, 0, -1, -1};
        ob = '{0, 0, 0, -1, -1};
        oc = '{0, 0, 0, -1, -1};
        if_a.start_i = use_a;
        if_b.start_i = use_b;
        if_c.start_i = use_c;
        @(negedge clk);
        if (mode != 1) begin
            if_a.start_i = 1'b0;
            if_b.start_i = 1'b0;
            if_c.start_i = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            sample(c, if_a.bram_en, int'(if_a.bram_addr), 5, 8192, 16, if_a.valid_o, oa);
            sample(c, if_b.bram_en, int'(if_b.bram_addr), 5, 8192, 16, if_b.valid_o, ob);
            sample(c, if_c.bram_en, int'(if_c.bram_addr), 14, 16, 4, if_c.valid_o, oc);
            busy_hist[c] = if_a.busy_o;
            if (mode == 2) if_a.start_i = (c % 5 == 4) && (c < 15);
            @(negedge clk);
        end
        if_a.start_i = 1'b0;
        if_b.start_i = 1'b0;
        if_c.start_i = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int inst, input int k);
        logic [8:0] ia;
        logic [6:0] ic;
        ia = 9'(k * 32);
        ic = 7'(k * 32);
        case (inst)
            0:       return if_a.data_o[ia +: 32];
            1:       return if_b.data_o[ia +: 32];
            2:       return if_c.data_o[ic +: 32];
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        int          inst;
        int          k;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{0, 0,  32'hA000_0000};
        vecs[1] = '{0, 1,  32'hA000_0001};
        vecs[2] = '{0, 7,  32'hA000_0007};
        vecs[3] = '{0, 15, 32'hA000_000F};
        vecs[4] = '{1, 0,  32'hA000_0000};
        vecs[5] = '{1, 15, 32'hA000_000F};
        vecs[6] = '{2, 0,  32'hC000_000E};
        vecs[7] = '{2, 1,  32'hC000_000F};
        vecs[8] = '{2, 2,  32'hC000_0000};
        vecs[9] = '{2, 3,  32'hC000_0001};

        if_a.start_i = 1'b0;
        if_b.start_i = 1'b0;
        if_c.start_i = 1'b0;
`ifdef BRAM_GATHER_ABORT_EN
        if_a.abort_i = 1'b0;
        if_b.abort_i = 1'b0;
        if_c.abort_i = 1'b0;
`endif

        @(negedge clk);
        chk("reset busy",   32'(if_a.busy_o),  32'd0);
        chk("reset valid",  32'(if_a.valid_o), 32'd0);
        chk("reset en",     32'(if_a.bram_en), 32'd0);
        chk("reset addr_a", 32'(if_a.bram_addr), 32'd5);
        chk("reset addr_c", 32'(if_c.bram_addr), 32'd14);
        chk("reset data",   32'(if_a.data_o == '0), 32'd1);
        chk("reset we",     32'(if_a.bram_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        observe(25, 0, 1'b1, 1'b1, 1'b1);
        chk("a en cycles",   oa.en_cnt,      16);
        chk("a addr seq",    oa.addr_bad,    0);
        chk("a valid count", oa.valid_cnt,   1);
        chk("a latency",     oa.valid_first, 17);
        chk("b en cycles",   ob.en_cnt,      16);
        chk("b latency",     ob.valid_first, 18);
        chk("b valid count", ob.valid_cnt,   1);
        chk("c en cycles",   oc.en_cnt,      4);
        chk("c addr wrap",   oc.addr_bad,    0);
        chk("c latency",     oc.valid_first, 5);
        chk("a busy idle",   32'(if_a.busy_o), 32'd0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("word inst%0d k%0d", vecs[i].inst, vecs[i].k),
                word_of(vecs[i].inst, vecs[i].k), vecs[i].exp);

        observe(36, 1, 1'b1, 1'b0, 1'b0);
        chk("held valid count",  oa.valid_cnt,   2);
        chk("held first valid",  oa.valid_first, 17);
        chk("held second valid", oa.valid_last,  35);
        chk("held busy at valid", 32'(busy_hist[17]), 32'd0);
        chk("held start in valid cycle", 32'(busy_hist[18]), 32'd1);
        chk("held en cycles",    oa.en_cnt,      32);
        chk("held word15", word_of(0, 15), 32'hA000_000F);
        repeat (20) @(negedge clk);

        observe(30, 2, 1'b1, 1'b0, 1'b0);
        chk("poke valid count", oa.valid_cnt,   1);
        chk("poke latency",     oa.valid_first, 17);
        chk("poke en cycles",   oa.en_cnt,      16);
        chk("poke addr seq",    oa.addr_bad,    0);

        if_a.start_i = 1'b1;
        @(negedge clk);
        if_a.start_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid en",   32'(if_a.bram_en),   32'd1);
        chk("mid addr", 32'(if_a.bram_addr), 32'd13);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy",  32'(if_a.busy_o),    32'd0);
        chk("async rst en",    32'(if_a.bram_en),   32'd0);
        chk("async rst addr",  32'(if_a.bram_addr), 32'd5);
        chk("async rst valid", 32'(if_a.valid_o),   32'd0);
        chk("async rst data",  32'(if_a.data_o == '0), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        observe(20, 0, 1'b0, 1'b0, 1'b0);
        chk("no valid after reset", oa.valid_cnt, 0);
        observe(22, 0, 1'b1, 1'b0, 1'b0);
        chk("regather latency", oa.valid_first, 17);
        chk("regather word0",   word_of(0, 0),  32'hA000_0000);
        chk("regather word15",  word_of(0, 15), 32'hA000_000F);

`ifdef BRAM_GATHER_ABORT_EN
        if_a.start_i = 1'b1;
        @(negedge clk);
        if_a.start_i = 1'b0;
        repeat (5) @(negedge clk);
        if_a.abort_i = 1'b1;
        @(negedge clk);
        if_a.abort_i = 1'b0;
        chk("abort busy", 32'(if_a.busy_o),    32'd0);
        chk("abort en",   32'(if_a.bram_en),   32'd0);
        chk("abort addr", 32'(if_a.bram_addr), 32'd5);
        observe(25, 0, 1'b0, 1'b0, 1'b0);
        chk("abort no valid", oa.valid_cnt,   0);
        chk("abort word0",    word_of(0, 0),  32'hA000_0000);
        chk("abort word15",   word_of(0, 15), 32'hA000_000F);
        if_a.start_i = 1'b1;
        if_a.abort_i = 1'b1;
        @(negedge clk);
        if_a.start_i = 1'b0;
        if_a.abort_i = 1'b0;
        chk("abort beats start", 32'(if_a.busy_o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
